// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Generic inter-stage register for the 5-stage MIPS pipeline (D/E, E/M, M/W).
// It carries a packed payload together with the PC, the destination register
// and the hazard-unit Tnew field. The stage can be stalled (hold) or replaced
// by a bubble (flush). Two saturating counters record stall cycles and
// inserted bubbles for performance debug.
//
// Ports:
//   clk        rising-edge clock for all state
//   reset      synchronous, active-high reset
//   hold       stall: keep the current contents
//   flush      insert a bubble (wins over hold)
//   clr_cnt    synchronous clear of both event counters
//   in_valid   upstream instruction valid
//   in_pc      upstream PC
//   in_data    upstream packed payload
//   in_a3      upstream destination register
//   in_tnew    upstream Tnew
//   out_valid  registered valid
//   out_pc     registered PC (BUBBLE_PC for a bubble)
//   out_data   registered payload
//   out_a3     registered destination register (0 = no write)
//   out_tnew   registered Tnew
//   hold_cnt   cycles in which hold took effect, saturating
//   bubble_cnt bubbles inserted by flush, saturating
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int              DATA_W    = 96,
   parameter int              PC_W      = 32,
   parameter logic [PC_W-1:0] BUBBLE_PC = 32'h00003000,
   parameter int              TNEW_W    = 2,
   parameter bit              TNEW_DEC  = 1'b1,
   parameter int              CNT_W     = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              flush,
   input  logic              clr_cnt,
   input  logic              in_valid,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [DATA_W-1:0] in_data,
   input  logic [4:0]        in_a3,
   input  logic [TNEW_W-1:0] in_tnew,
   output logic              out_valid,
   output logic [PC_W-1:0]   out_pc,
   output logic [DATA_W-1:0] out_data,
   output logic [4:0]        out_a3,
   output logic [TNEW_W-1:0] out_tnew,
   output logic [CNT_W-1:0]  hold_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   // Tnew as seen by the next stage: one cycle closer to producing its result.
   // Floors at zero so a finished producer never wraps back to "far away".
   logic [TNEW_W-1:0] tnew_load;

   always_comb begin
      // NOTE: default assigned first so no path through the block leaves
      // tnew_load unassigned, which would otherwise infer a latch.
      tnew_load = in_tnew;
      if (TNEW_DEC && (in_tnew != '0)) begin
         tnew_load = in_tnew - TNEW_W'(1);
      end
   end

   // Pipeline contents: reset > flush > hold > load.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the values
      // present before the edge, independent of statement order.
      if (reset || flush) begin
         out_valid <= 1'b0;
         out_pc    <= BUBBLE_PC;
         out_data  <= '0;
         out_a3    <= '0;
         out_tnew  <= '0;
      end else if (!hold) begin
         out_valid <= in_valid;
         out_pc    <= in_pc;
         out_data  <= in_data;
         // An invalid slot must never look like a pending register write.
         out_a3    <= in_valid ? in_a3 : 5'd0;
         out_tnew  <= in_valid ? tnew_load : '0;
      end
   end

   // Event counters. A flush+hold cycle is a bubble only; clear beats counting.
   always_ff @(posedge clk) begin
      if (reset || clr_cnt) begin
         hold_cnt   <= '0;
         bubble_cnt <= '0;
      end else begin
         if (flush && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
         end
         if (hold && !flush && (hold_cnt != '1)) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Two instances share one stimulus stream: dut uses the default parameters,
// dut_s uses 2-bit counters so saturation is reachable in a few cycles.
// Directed table, hand-written counter sequences, then randomized stimulus
// against a behavioural model.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

   localparam logic [31:0] BPC = 32'h00003000;

   typedef struct {
      logic        v;
      logic [31:0] pc;
      logic [95:0] data;
      logic [4:0]  a3;
      logic [1:0]  tnew;
      int          hc;
      int          bc;
      int          shc;
      int          sbc;
   } exp_t;

   typedef struct {
      logic        reset, hold, flush, clr, valid;
      logic [31:0] pc;
      logic [95:0] data;
      logic [4:0]  a3;
      logic [1:0]  tnew;
      exp_t        e;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset, hold, flush, clr_cnt, in_valid;
   logic [31:0] in_pc;
   logic [95:0] in_data;
   logic [4:0]  in_a3;
   logic [1:0]  in_tnew;

   logic        out_valid, s_out_valid;
   logic [31:0] out_pc, s_out_pc;
   logic [95:0] out_data, s_out_data;
   logic [4:0]  out_a3, s_out_a3;
   logic [1:0]  out_tnew, s_out_tnew;
   logic [15:0] hold_cnt, bubble_cnt;
   logic [1:0]  s_hold_cnt, s_bubble_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   pipe_stage_reg dut (
      .clk(clk), .reset(reset), .hold(hold), .flush(flush), .clr_cnt(clr_cnt),
      .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data), .in_a3(in_a3),
      .in_tnew(in_tnew), .out_valid(out_valid), .out_pc(out_pc),
      .out_data(out_data), .out_a3(out_a3), .out_tnew(out_tnew),
      .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt)
   );

   pipe_stage_reg #(.CNT_W(2)) dut_s (
      .clk(clk), .reset(reset), .hold(hold), .flush(flush), .clr_cnt(clr_cnt),
      .in_valid(in_valid), .in_pc(in_pc), .in_data(in_data), .in_a3(in_a3),
      .in_tnew(in_tnew), .out_valid(s_out_valid), .out_pc(s_out_pc),
      .out_data(s_out_data), .out_a3(s_out_a3), .out_tnew(s_out_tnew),
      .hold_cnt(s_hold_cnt), .bubble_cnt(s_bubble_cnt)
   );

   task automatic check(input string name, input logic [127:0] act,
                        input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_all(input string tag, input exp_t e);
      check({tag, ".valid"},   128'(out_valid),    128'(e.v));
      check({tag, ".pc"},      128'(out_pc),       128'(e.pc));
      check({tag, ".data"},    128'(out_data),     128'(e.data));
      check({tag, ".a3"},      128'(out_a3),       128'(e.a3));
      check({tag, ".tnew"},    128'(out_tnew),     128'(e.tnew));
      check({tag, ".hold_cnt"},   128'(hold_cnt),   128'(e.hc));
      check({tag, ".bubble_cnt"}, 128'(bubble_cnt), 128'(e.bc));
      check({tag, ".s_pc"},    128'(s_out_pc),     128'(e.pc));
      check({tag, ".s_a3"},    128'(s_out_a3),     128'(e.a3));
      check({tag, ".s_hold_cnt"},   128'(s_hold_cnt),   128'(e.shc));
      check({tag, ".s_bubble_cnt"}, 128'(s_bubble_cnt), 128'(e.sbc));
   endtask

   task automatic drive(input logic r, h, f, c, v, input logic [31:0] pc,
                        input logic [95:0] d, input logic [4:0] a3,
                        input logic [1:0] t);
      reset = r; hold = h; flush = f; clr_cnt = c; in_valid = v;
      in_pc = pc; in_data = d; in_a3 = a3; in_tnew = t;
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk(input logic v, input logic [31:0] pc,
                               input logic [95:0] d, input logic [4:0] a3,
                               input logic [1:0] t, input int hc, bc,
                               input int shc, sbc);
      exp_t e;
      e.v = v; e.pc = pc; e.data = d; e.a3 = a3; e.tnew = t;
      e.hc = hc; e.bc = bc; e.shc = shc; e.sbc = sbc;
      return e;
   endfunction

   // Behavioural model state
   exp_t m;

   function automatic int sat_inc(input int x, input int maxv);
      return (x >= maxv) ? maxv : x + 1;
   endfunction

   task automatic model_edge;
      if (reset) begin
         m = mk(1'b0, BPC, '0, '0, '0, 0, 0, 0, 0);
         return;
      end
      if (clr_cnt) begin
         m.hc = 0; m.bc = 0; m.shc = 0; m.sbc = 0;
      end else if (flush) begin
         m.bc  = sat_inc(m.bc, 65535);
         m.sbc = sat_inc(m.sbc, 3);
      end else if (hold) begin
         m.hc  = sat_inc(m.hc, 65535);
         m.shc = sat_inc(m.shc, 3);
      end
      if (flush) begin
         m.v = 1'b0; m.pc = BPC; m.data = '0; m.a3 = '0; m.tnew = '0;
      end else if (!hold) begin
         m.v    = in_valid;
         m.pc   = in_pc;
         m.data = in_data;
         if (in_valid) begin
            m.a3   = in_a3;
            m.tnew = (int'(in_tnew) > 0) ? 2'(int'(in_tnew) - 1) : 2'd0;
         end else begin
            m.a3 = '0; m.tnew = '0;
         end
      end
   endtask

   vec_t vecs[15];

   initial begin
      // Directed table: each row is one edge; expectations after that edge.
      vecs[0]  = '{1,1,0,0,1, 32'h3010, 96'hF, 5'd9, 2'd3, mk(0, BPC, 0, 0, 0, 0,0,0,0)};
      vecs[1]  = '{1,1,0,0,1, 32'h3010, 96'hF, 5'd9, 2'd3, mk(0, BPC, 0, 0, 0, 0,0,0,0)};
      vecs[2]  = '{0,0,0,0,1, 32'h3004, 96'h1_2_3, 5'd5, 2'd2,
                   mk(1, 32'h3004, 96'h1_2_3, 5, 1, 0,0,0,0)};
      vecs[3]  = '{0,0,0,0,1, 32'h3004, 96'h1_2_3, 5'd5, 2'd0,
                   mk(1, 32'h3004, 96'h1_2_3, 5, 0, 0,0,0,0)};
      vecs[4]  = '{0,0,0,0,1, 32'h3008, 96'hAA, 5'd7, 2'd1,
                   mk(1, 32'h3008, 96'hAA, 7, 0, 0,0,0,0)};
      vecs[5]  = '{0,1,0,0,1, 32'h300C, 96'hBB, 5'd8, 2'd3,
                   mk(1, 32'h3008, 96'hAA, 7, 0, 1,0,1,0)};
      vecs[6]  = '{0,1,0,0,1, 32'h3010, 96'hCC, 5'd9, 2'd3,
                   mk(1, 32'h3008, 96'hAA, 7, 0, 2,0,2,0)};
      vecs[7]  = '{0,1,0,0,0, 32'h3014, 96'hDD, 5'd1, 2'd2,
                   mk(1, 32'h3008, 96'hAA, 7, 0, 3,0,3,0)};
      vecs[8]  = '{0,1,1,0,1, 32'h3018, 96'hEE, 5'd2, 2'd2,
                   mk(0, BPC, 0, 0, 0, 3,1,3,1)};
      vecs[9]  = '{0,0,0,0,0, 32'h3020, 96'h55, 5'd31, 2'd3,
                   mk(0, 32'h3020, 96'h55, 0, 0, 3,1,3,1)};
      vecs[10] = '{0,0,0,0,1, 32'h300C, 96'h77, 5'd4, 2'd3,
                   mk(1, 32'h300C, 96'h77, 4, 2, 3,1,3,1)};
      vecs[11] = '{1,1,1,0,1, 32'h3040, 96'h99, 5'd6, 2'd1,
                   mk(0, BPC, 0, 0, 0, 0,0,0,0)};
      vecs[12] = '{0,1,0,0,1, 32'h3030, 96'h11, 5'd3, 2'd1,
                   mk(0, BPC, 0, 0, 0, 1,0,1,0)};
      vecs[13] = '{0,1,0,1,1, 32'h3034, 96'h22, 5'd3, 2'd1,
                   mk(0, BPC, 0, 0, 0, 0,0,0,0)};
      vecs[14] = '{0,0,1,1,1, 32'h3038, 96'h33, 5'd3, 2'd1,
                   mk(0, BPC, 0, 0, 0, 0,0,0,0)};

      drive(1, 0, 0, 0, 0, '0, '0, '0, '0);
      @(negedge clk);

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].reset, vecs[i].hold, vecs[i].flush, vecs[i].clr,
               vecs[i].valid, vecs[i].pc, vecs[i].data, vecs[i].a3,
               vecs[i].tnew);
         step();
         check_all($sformatf("vec%0d", i), vecs[i].e);
      end

      // Bubble counter saturation: 2-bit counter reads 1,2,3,3,3,3.
      drive(1, 0, 0, 0, 0, '0, '0, '0, '0);
      step();
      for (int i = 1; i <= 6; i++) begin
         drive(0, 0, 1, 0, 1, 32'h3100, 96'h1, 5'd1, 2'd1);
         step();
         check($sformatf("sat_bubble%0d.s", i), 128'(s_bubble_cnt),
               128'((i > 3) ? 3 : i));
         check($sformatf("sat_bubble%0d", i), 128'(bubble_cnt), 128'(i));
      end
      // Clear wins over a simultaneous flush.
      drive(0, 0, 1, 1, 1, 32'h3100, 96'h1, 5'd1, 2'd1);
      step();
      check("clr_flush.s", 128'(s_bubble_cnt), 128'(0));
      check("clr_flush", 128'(bubble_cnt), 128'(0));
      check("clr_flush.pc", 128'(out_pc), 128'(BPC));

      // Hold counter saturation on the narrow instance.
      for (int i = 1; i <= 5; i++) begin
         drive(0, 1, 0, 0, 1, 32'h3200, 96'h2, 5'd2, 2'd2);
         step();
         check($sformatf("sat_hold%0d.s", i), 128'(s_hold_cnt),
               128'((i > 3) ? 3 : i));
         check($sformatf("sat_hold%0d", i), 128'(hold_cnt), 128'(i));
      end

      // Randomized stimulus against the behavioural model.
      drive(1, 0, 0, 0, 0, '0, '0, '0, '0);
      step();
      model_edge();
      check_all("rnd_reset", m);
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 3) != 0), $urandom,
               {$urandom, $urandom, $urandom}, 5'($urandom), 2'($urandom));
         step();
         model_edge();
         check_all($sformatf("rnd%0d", i), m);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage register for the 5-stage MIPS pipeline, used for D/E, E/M and M/W in place of the per-stage hand-written registers. It carries a generic packed payload plus the PC, destination register and hazard-unit Tnew field. It has separate hold (stall) and flush (bubble) controls and a valid bit. Saturating hold/bubble event counters feed the performance-debug path.

Parameters:
DATA_W, 96, width of packed payload (e.g. O1|O2|EXT_O)
PC_W, 32, PC width
BUBBLE_PC, 32'h00003000, PC value loaded on reset/flush
TNEW_W, 2, width of Tnew field
TNEW_DEC, 1, 1 = decrement Tnew (floor 0) when loading; 0 = pass through unchanged
CNT_W, 16, width of hold/bubble counters

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
hold  in  1  keep current contents (stage stalled)
flush  in  1  load a bubble
clr_cnt  in  1  synchronous clear of both event counters
in_valid  in  1  upstream instruction valid
in_pc  in  PC_W  upstream PC
in_data  in  DATA_W  upstream payload
in_a3  in  5  upstream destination register
in_tnew  in  TNEW_W  upstream Tnew
out_valid  out  1  registered valid
out_pc  out  PC_W  registered PC
out_data  out  DATA_W  registered payload
out_a3  out  5  registered destination register (0 = no write)
out_tnew  out  TNEW_W  registered Tnew
hold_cnt  out  CNT_W  cycles in which hold took effect, saturating
bubble_cnt  out  CNT_W  bubbles inserted by flush, saturating

Behaviour:
- Single-cycle latency: inputs sampled at posedge appear on out_* after that edge; no combinational in->out path.
- Register update priority per edge: reset > flush > hold > load.
  - reset: out_valid=0, out_pc=BUBBLE_PC, out_data=0, out_a3=0, out_tnew=0, hold_cnt=0, bubble_cnt=0.
  - flush (with or without hold): bubble loaded, same values as reset for out_*; counters not cleared.
  - hold (no flush): all out_* keep their values.
  - load: out_valid=in_valid, out_pc=in_pc, out_data=in_data.
    - if in_valid=0: out_a3=0, out_tnew=0, so an invalid slot never creates a hazard.
    - otherwise out_a3=in_a3; out_tnew = (TNEW_DEC && in_tnew!=0) ? in_tnew-1 : in_tnew.
- Tnew arithmetic is unsigned TNEW_W bits. Decrement floors at 0 and never wraps to all-ones.
- Counters, evaluated each edge when reset=0:
  - clr_cnt=1: both counters go to 0, taking precedence over increments in the same cycle.
  - else bubble_cnt += 1 if flush=1.
  - else hold_cnt += 1 if hold=1 && flush=0.
  - Both saturate at 2^CNT_W-1: held at max, no wrap.
- Flush and hold together count as a bubble only; hold_cnt is unchanged.
- Reset mid-hold or mid-flush sequence: reset wins and all state returns to reset values on that edge. Hold/flush values asserted during the reset cycle have no effect.
- No initial blocks. Power-up state is defined only by reset.

Test Plan:
- Reset: reset=1 for 2 cycles with in_valid=1, in_pc=0x3010, hold=1 -> out_valid=0, out_pc=0x00003000, out_data=0, out_a3=0, out_tnew=0, both counters 0.
- Load with Tnew decrement: in_valid=1, in_pc=0x3004, in_data=96'h1_2_3, in_a3=5, in_tnew=2 -> next cycle out_pc=0x3004, out_a3=5, out_tnew=1. Same with in_tnew=0 -> out_tnew=0.
- Hold then flush:
  - Load pc=0x3008, then hold=1 for 3 cycles while in_pc changes -> out_pc stays 0x3008, hold_cnt=3.
  - Then flush=1 with hold=1 for 1 cycle -> out_valid=0, out_pc=0x3000, out_a3=0, bubble_cnt=1, hold_cnt=3.
- Invalid slot masking: in_valid=0, in_a3=31, in_tnew=3 -> out_a3=0, out_tnew=0, out_pc=in_pc.
- Counter saturation and clear:
  - CNT_W=2, flush held 6 cycles -> bubble_cnt reads 1, 2, 3, 3, 3, 3.
  - clr_cnt=1 with flush=1 -> bubble_cnt=0 next cycle.
- Reset during hold: after loading pc=0x300c, assert hold=1 and reset=1 together -> out_pc=0x3000, hold_cnt=0 on that edge.
